mem_arbiter: RTL and testbench

Single-port memory arbiter between the fetch stage (instruction reads) and the mem stage (data loads/stores) of the pipeline CPU. It presents one request/response interface per requester and drives one shared memory port with a variable-latency address/data handshake. Each requester waits on its own `*_ok` pulse, and the hazard unit holds `stallF` / the mem-stage stall while that requester has a request pending and no `*_ok` has arrived.

---
 rtl/arb_pkg.sv | 15 +
 rtl/bus_watchdog.sv | 39 +++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the fetch/mem-stage memory arbiter.
package arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    D_ADDR,
    D_WAIT,
    I_ADDR,
    I_WAIT
  } arbState_t;

  localparam logic [3:0] SEL_WORD = 4'b1111;
  localparam int unsigned WAIT_LIMIT_DEFAULT = 255;

endpackage

// File: rtl/bus_watchdog.sv
// Per-transaction cycle counter; fires a one-cycle timeout and sets a sticky bus error.
module bus_watchdog
  import arb_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout,
  output logic bus_err
);

  localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  // Timeout fires on the cycle the count would step up to WAIT_LIMIT.
  localparam logic [CW-1:0] LAST_COUNT = (WAIT_LIMIT == 0) ? '0 : CW'(WAIT_LIMIT - 1);

  logic [CW-1:0] countReg;

  assign timeout = (WAIT_LIMIT != 0) && en && (countReg == LAST_COUNT);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      countReg <= '0;
    end else if (en) begin
      countReg <= countReg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else if (timeout) begin
      bus_err <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch reads and mem-stage loads/stores share one
// variable-latency memory port; data requests win ties, one transaction at a time.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_sel,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ok,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  arbState_t   stateReg, stateNext;
  logic        memReqNext, memWrNext;
  logic [3:0]  memSelNext;
  logic [31:0] memAddrNext, memWdataNext;
  logic [31:0] instRdataNext, dataRdataNext;
  logic        instOkNext, dataOkNext;
  logic        inAddr, inWait, isData, memDone, timeout;

  assign inAddr  = (stateReg == D_ADDR) || (stateReg == I_ADDR);
  assign inWait  = (stateReg == D_WAIT) || (stateReg == I_WAIT);
  assign isData  = (stateReg == D_ADDR) || (stateReg == D_WAIT);
  assign memDone = (inAddr && mem_addr_ok && mem_data_ok) || (inWait && mem_data_ok);

  // The completing cycle is not counted, so a real reply always beats the watchdog.
  bus_watchdog #(
    .WAIT_LIMIT(WAIT_LIMIT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (stateReg == IDLE),
    .en     ((inAddr || inWait) && !memDone),
    .timeout(timeout),
    .bus_err(bus_err)
  );

  always_comb begin
    stateNext     = stateReg;
    memWrNext     = mem_wr;
    memSelNext    = mem_sel;
    memAddrNext   = mem_addr;
    memWdataNext  = mem_wdata;
    instRdataNext = inst_rdata;
    dataRdataNext = data_rdata;
    instOkNext    = 1'b0;
    dataOkNext    = 1'b0;

    case (stateReg)
      IDLE: begin
        // A requester still holding req in its own ok cycle is a stale request.
        if (data_req && !data_ok) begin
          stateNext    = D_ADDR;
          memWrNext    = data_wr;
          memSelNext   = data_sel;
          memAddrNext  = data_addr;
          memWdataNext = data_wdata;
        end else if (inst_req && !inst_ok) begin
          stateNext    = I_ADDR;
          memWrNext    = 1'b0;
          memSelNext   = SEL_WORD;
          memAddrNext  = inst_addr;
        end
      end
      D_ADDR: if (mem_addr_ok) stateNext = D_WAIT;
      I_ADDR: if (mem_addr_ok) stateNext = I_WAIT;
      default: ;
    endcase

    if (memDone || timeout) begin
      stateNext = IDLE;
      if (isData) begin
        dataOkNext = 1'b1;
        if (!mem_wr) dataRdataNext = timeout ? 32'h0 : mem_rdata;
      end else begin
        instOkNext    = 1'b1;
        instRdataNext = timeout ? 32'h0 : mem_rdata;
      end
    end

    memReqNext = (stateNext == D_ADDR) || (stateNext == I_ADDR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg   <= IDLE;
      mem_req    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_sel    <= 4'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      inst_rdata <= 32'h0;
      data_rdata <= 32'h0;
      inst_ok    <= 1'b0;
      data_ok    <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      mem_req    <= memReqNext;
      mem_wr     <= memWrNext;
      mem_sel    <= memSelNext;
      mem_addr   <= memAddrNext;
      mem_wdata  <= memWdataNext;
      inst_rdata <= instRdataNext;
      data_rdata <= dataRdataNext;
      inst_ok    <= instOkNext;
      data_ok    <= dataOkNext;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions are queued at request time
// and checked against each inst_ok/data_ok pulse (kind, data and arrival cycle).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_sel;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_ok, data_ok;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        bus_err;

  typedef struct {
    bit          isData;
    logic [31:0] rdata;
    int          cycle;
  } expOk_t;

  expOk_t sbQ[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;

  mem_arbiter #(.WAIT_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
    .data_req(data_req), .data_wr(data_wr), .data_sel(data_sel), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ok(data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, act, exp, cyc);
    end else begin
      $display("ok   %s: %08h (cycle %0d)", tag, act, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input bit isData, input logic [31:0] rdata, input int cycle);
    expOk_t e;
    e.isData = isData;
    e.rdata  = rdata;
    e.cycle  = cycle;
    sbQ.push_back(e);
  endtask

  // Completion monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (inst_ok || data_ok) begin
      if (sbQ.size() == 0) begin
        check("spurious_ok", {30'h0, inst_ok, data_ok}, 32'h0);
      end else begin
        expOk_t e;
        e = sbQ.pop_front();
        check("ok_kind", {30'h0, inst_ok, data_ok}, e.isData ? 32'h1 : 32'h2);
        check("ok_rdata", e.isData ? data_rdata : inst_rdata, e.rdata);
        check("ok_cycle", cyc, e.cycle);
      end
    end
  end

  initial begin
    int c0;
    rst = 1'b1;
    inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_sel = 0;
    data_addr = 0; data_wdata = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    tick(3);
    rst = 1'b0;
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_sel", {28'h0, mem_sel}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_oks_err", {29'h0, inst_ok, data_ok, bus_err}, 32'h0);

    // Single load, addr_ok in cycle 1, data_ok in cycle 3.
    tick(1);
    c0 = cyc;
    data_req = 1; data_wr = 0; data_sel = 4'b1100; data_addr = 32'h100;
    pushExp(1'b1, 32'hDEADBEEF, c0 + 4);
    tick(1);
    check("ld_mem_req", {31'h0, mem_req}, 32'h1);
    check("ld_mem_addr", mem_addr, 32'h100);
    check("ld_mem_wr_sel", {27'h0, mem_wr, mem_sel}, {27'h0, 1'b0, 4'b1100});
    mem_addr_ok = 1;
    tick(1);
    mem_addr_ok = 0;
    check("ld_wait_req", {31'h0, mem_req}, 32'h0);
    tick(1);
    mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
    tick(1);
    mem_data_ok = 0;
    tick(1);
    data_req = 0;
    check("ld_no_reaccept", {31'h0, mem_req}, 32'h0);

    // Simultaneous store and fetch: store first, fetch starts after data_ok.
    tick(1);
    c0 = cyc;
    inst_req = 1; inst_addr = 32'h0;
    data_req = 1; data_wr = 1; data_sel = 4'b0011; data_addr = 32'h200; data_wdata = 32'h1234;
    pushExp(1'b1, 32'hDEADBEEF, c0 + 2);
    pushExp(1'b0, 32'hCAFE0001, c0 + 6);
    tick(1);
    check("st_mem_addr", mem_addr, 32'h200);
    check("st_mem_wdata", mem_wdata, 32'h1234);
    check("st_mem_wr_sel", {27'h0, mem_wr, mem_sel}, {27'h0, 1'b1, 4'b0011});
    mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h77777777;
    tick(1);
    mem_addr_ok = 0; mem_data_ok = 0;
    tick(1);
    data_req = 0;
    check("if_mem_req", {31'h0, mem_req}, 32'h1);
    check("if_mem_addr", mem_addr, 32'h0);
    check("if_mem_wr_sel", {27'h0, mem_wr, mem_sel}, {27'h0, 1'b0, 4'b1111});
    mem_addr_ok = 1;
    tick(1);
    mem_addr_ok = 0;
    tick(1);
    mem_data_ok = 1; mem_rdata = 32'hCAFE0001;
    tick(1);
    mem_data_ok = 0;
    tick(1);
    inst_req = 0;

    // Zero-wait fetches: each completes two cycles after its request is sampled.
    for (int i = 0; i < 10; i++) begin
      c0 = cyc;
      inst_req = 1; inst_addr = 32'h1000 + 32'(i * 4);
      pushExp(1'b0, 32'hA0000000 + 32'(i), c0 + 2);
      tick(1);
      check("zw_mem_addr", mem_addr, 32'h1000 + 32'(i * 4));
      mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hA0000000 + 32'(i);
      tick(1);
      mem_addr_ok = 0; mem_data_ok = 0;
      tick(1);
    end
    inst_req = 0;
    tick(1);

    // Watchdog: memory never answers, forced completion after 8 busy cycles.
    c0 = cyc;
    inst_req = 1; inst_addr = 32'h40;
    pushExp(1'b0, 32'h0, c0 + 9);
    tick(8);
    check("wd_still_req", {31'h0, mem_req}, 32'h1);
    check("wd_err_before", {31'h0, bus_err}, 32'h0);
    tick(1);
    check("wd_err_set", {31'h0, bus_err}, 32'h1);
    tick(1);
    inst_req = 0;
    tick(3);
    check("wd_err_sticky", {31'h0, bus_err}, 32'h1);
    check("wd_idle_req", {31'h0, mem_req}, 32'h0);

    // Stray handshake in IDLE.
    mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hBAD0BAD0;
    tick(1);
    mem_addr_ok = 0; mem_data_ok = 0;
    tick(1);
    check("stray_req", {31'h0, mem_req}, 32'h0);
    check("stray_rdata", inst_rdata, 32'h0);

    // Reset mid-transaction, then a late data_ok.
    c0 = cyc;
    data_req = 1; data_wr = 0; data_sel = 4'b1111; data_addr = 32'h300;
    tick(1);
    mem_addr_ok = 1;
    tick(1);
    mem_addr_ok = 0; rst = 1; data_req = 0;
    tick(1);
    rst = 0;
    check("rr_mem_req", {31'h0, mem_req}, 32'h0);
    check("rr_mem_addr", mem_addr, 32'h0);
    check("rr_mem_sel", {28'h0, mem_sel}, 32'h0);
    check("rr_rdata", data_rdata | inst_rdata, 32'h0);
    check("rr_err_cleared", {31'h0, bus_err}, 32'h0);
    mem_data_ok = 1; mem_rdata = 32'h55555555;
    tick(1);
    mem_data_ok = 0;
    tick(2);
    check("rr_late_req", {31'h0, mem_req}, 32'h0);
    check("rr_late_rdata", data_rdata, 32'h0);

    check("sb_empty", 32'(sbQ.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
